// File: rtl/alu_seq.sv
// Registered sequential ALU: single-cycle logic/arith ops plus iterative unsigned
// modulo/divide (restoring) and multiply (shift-add) behind one start/done handshake.
module alu_seq #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 6
) (
   input  logic             clk_i,
   input  logic             reset_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic [3:0]       aluop_i,
   output logic [WIDTH-1:0] res_o,
   output logic             done_o,
   output logic             busy_o,
   output logic             carry_o,
   output logic             overflow_o,
   output logic             zero_o,
   output logic             div_zero_o,
   output logic             illegal_o
);

   localparam logic [3:0] OP_AND  = 4'd0;
   localparam logic [3:0] OP_OR   = 4'd1;
   localparam logic [3:0] OP_XOR  = 4'd2;
   localparam logic [3:0] OP_NOR  = 4'd3;
   localparam logic [3:0] OP_SLT  = 4'd4;
   localparam logic [3:0] OP_ADD  = 4'd5;
   localparam logic [3:0] OP_SUB  = 4'd6;
   localparam logic [3:0] OP_MOD  = 4'd7;
   localparam logic [3:0] OP_DIV  = 4'd8;
   localparam logic [3:0] OP_MUL  = 4'd9;
   localparam logic [3:0] OP_SLTU = 4'd10;

   typedef enum logic [1:0] {S_IDLE, S_ITER, S_FIN} state_e;

   state_e             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [3:0]         op_q, op_d;
   logic [WIDTH-1:0]   acc_q, acc_d;   // remainder (MOD/DIV) or partial product (MUL)
   logic [WIDTH-1:0]   quo_q, quo_d;   // dividend/quotient shifter or multiplier
   logic [WIDTH-1:0]   opb_q, opb_d;   // divisor or shifted multiplicand
   logic [WIDTH-1:0]   res_q, res_d;
   logic               done_q, done_d;
   logic               busy_q, busy_d;
   logic               carry_q, carry_d;
   logic               ovf_q, ovf_d;
   logic               zero_q, zero_d;
   logic               dz_q, dz_d;
   logic               ill_q, ill_d;

   logic [WIDTH:0]     add_w, sub_w, rs_w, rsub_w;
   logic [WIDTH-1:0]   fin_res;
   logic               fin, go_iter, fin_carry, fin_ovf, fin_dz, fin_ill;

   // Next-state, datapath and registered-output computation
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      acc_d     = acc_q;
      quo_d     = quo_q;
      opb_d     = opb_q;
      res_d     = res_q;
      carry_d   = carry_q;
      ovf_d     = ovf_q;
      zero_d    = zero_q;
      dz_d      = dz_q;
      ill_d     = ill_q;
      done_d    = 1'b0;
      busy_d    = 1'b0;
      fin       = 1'b0;
      go_iter   = 1'b0;
      fin_res   = '0;
      fin_carry = 1'b0;
      fin_ovf   = 1'b0;
      fin_dz    = 1'b0;
      fin_ill   = 1'b0;

      add_w  = {1'b0, a_i} + {1'b0, b_i};
      sub_w  = {1'b0, a_i} + {1'b0, ~b_i} + (WIDTH+1)'(1);
      rs_w   = {acc_q, quo_q[WIDTH-1]};
      rsub_w = rs_w - {1'b0, opb_q};

      case (state_q)
         S_ITER: begin
            if (op_q == OP_MUL) begin
               if (quo_q[0]) acc_d = acc_q + opb_q;
               opb_d = {opb_q[WIDTH-2:0], 1'b0};
               quo_d = {1'b0, quo_q[WIDTH-1:1]};
            end else if (!rsub_w[WIDTH]) begin
               acc_d = rsub_w[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
               acc_d = rs_w[WIDTH-1:0];
               quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_d == CNT_W'(WIDTH)) begin
               fin     = 1'b1;
               fin_res = (op_q == OP_DIV) ? quo_d : acc_d;
            end
         end
         default: begin
            // FIN behaves as IDLE so a start in the done cycle is taken
            state_d = S_IDLE;
            if (start_i) begin
               case (aluop_i)
                  OP_AND:  fin_res = a_i & b_i;
                  OP_OR:   fin_res = a_i | b_i;
                  OP_XOR:  fin_res = a_i ^ b_i;
                  OP_NOR:  fin_res = ~(a_i | b_i);
                  OP_SLT:  fin_res = WIDTH'($signed(a_i) < $signed(b_i));
                  OP_SLTU: fin_res = WIDTH'(a_i < b_i);
                  OP_ADD: begin
                     fin_res   = add_w[WIDTH-1:0];
                     fin_carry = add_w[WIDTH];
                     fin_ovf   = (a_i[WIDTH-1] == b_i[WIDTH-1]) &&
                                 (add_w[WIDTH-1] != a_i[WIDTH-1]);
                  end
                  OP_SUB: begin
                     fin_res   = sub_w[WIDTH-1:0];
                     fin_carry = sub_w[WIDTH];
                     fin_ovf   = (a_i[WIDTH-1] != b_i[WIDTH-1]) &&
                                 (sub_w[WIDTH-1] != a_i[WIDTH-1]);
                  end
                  OP_MOD, OP_DIV: begin
                     if (b_i == '0) begin
                        fin_res = (aluop_i == OP_DIV) ? '1 : a_i;
                        fin_dz  = 1'b1;
                     end else begin
                        go_iter = 1'b1;
                     end
                  end
                  OP_MUL:  go_iter = 1'b1;
                  default: fin_ill = 1'b1;
               endcase
               fin = !go_iter;
            end
            if (go_iter) begin
               state_d = S_ITER;
               cnt_d   = '0;
               op_d    = aluop_i;
               acc_d   = '0;
               quo_d   = (aluop_i == OP_MUL) ? b_i : a_i;
               opb_d   = (aluop_i == OP_MUL) ? a_i : b_i;
            end
         end
      endcase

      if (fin) begin
         state_d = S_FIN;
         done_d  = 1'b1;
         res_d   = fin_res;
         carry_d = fin_carry;
         ovf_d   = fin_ovf;
         zero_d  = (fin_res == '0);
         dz_d    = fin_dz;
         ill_d   = fin_ill;
      end
      busy_d = (state_d == S_ITER);
   end

   always_ff @(posedge clk_i) begin
      if (!reset_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         acc_q   <= '0;
         quo_q   <= '0;
         opb_q   <= '0;
         res_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
         zero_q  <= 1'b0;
         dz_q    <= 1'b0;
         ill_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         acc_q   <= acc_d;
         quo_q   <= quo_d;
         opb_q   <= opb_d;
         res_q   <= res_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         carry_q <= carry_d;
         ovf_q   <= ovf_d;
         zero_q  <= zero_d;
         dz_q    <= dz_d;
         ill_q   <= ill_d;
      end
   end

   assign res_o      = res_q;
   assign done_o     = done_q;
   assign busy_o     = busy_q;
   assign carry_o    = carry_q;
   assign overflow_o = ovf_q;
   assign zero_o     = zero_q;
   assign div_zero_o = dz_q;
   assign illegal_o  = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: hand-computed vectors, one task per feature.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        reset, start;
   logic [31:0] a, b;
   logic [3:0]  aluop;
   logic [31:0] res;
   logic        done, busy, carry, overflow, zero, div_zero, illegal;

   int n_vec = 0;
   int n_err = 0;

   alu_seq #(.WIDTH(32), .CNT_W(6)) dut (
      .clk_i(clk), .reset_i(reset), .start_i(start), .a_i(a), .b_i(b),
      .aluop_i(aluop), .res_o(res), .done_o(done), .busy_o(busy),
      .carry_o(carry), .overflow_o(overflow), .zero_o(zero),
      .div_zero_o(div_zero), .illegal_o(illegal)
   );

   always #5 clk = ~clk;

   // Present one request for one edge; returns #1 into the cycle after accept
   task automatic drive(input logic [3:0] op, input logic [31:0] av, input logic [31:0] bv);
      @(negedge clk);
      start = 1'b1; aluop = op; a = av; b = bv;
      @(posedge clk);
      #1;
      start = 1'b0;
   endtask

   // Step cycles from index k0 until done; lat=0 if it never comes
   task automatic wait_done(input int k0, output int lat, output int nbusy);
      lat = 0; nbusy = 0;
      for (int k = k0; k <= 60; k++) begin
         if (done) begin lat = k; break; end
         if (busy) nbusy++;
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      reset = 1'b0; start = 1'b0; a = '0; b = '0; aluop = '0;
      repeat (2) @(posedge clk);
      #1;
      n_vec++; if (res !== 32'h0) begin n_err++; $display("FAIL reset_res got %h exp %h", res, 32'h0); end
      n_vec++; if ({done, busy} !== 2'b00) begin n_err++; $display("FAIL reset_done_busy got %b exp 00", {done, busy}); end
      n_vec++; if ({carry, overflow, zero, div_zero, illegal} !== 5'b0) begin
         n_err++; $display("FAIL reset_flags got %b exp 00000", {carry, overflow, zero, div_zero, illegal}); end
      @(negedge clk); reset = 1'b1;
   endtask

   task automatic test_add;
      drive(4'd5, 32'hFFFF_FFFF, 32'h1);
      n_vec++; if ({done, busy} !== 2'b10) begin n_err++; $display("FAIL add_done_busy got %b exp 10", {done, busy}); end
      n_vec++; if (res !== 32'h0) begin n_err++; $display("FAIL add_res got %h exp %h", res, 32'h0); end
      n_vec++; if ({carry, overflow, zero} !== 3'b101) begin n_err++; $display("FAIL add_flags got %b exp 101", {carry, overflow, zero}); end
      @(posedge clk); #1;
      n_vec++; if (done !== 1'b0) begin n_err++; $display("FAIL add_done_pulse got %b exp 0", done); end
      n_vec++; if ({res, carry, zero} !== {32'h0, 2'b11}) begin n_err++; $display("FAIL add_hold got %h/%b%b exp 0/11", res, carry, zero); end
      drive(4'd5, 32'h7FFF_FFFF, 32'h1);
      n_vec++; if (res !== 32'h8000_0000) begin n_err++; $display("FAIL add_ovf_res got %h exp 80000000", res); end
      n_vec++; if ({carry, overflow, zero} !== 3'b010) begin n_err++; $display("FAIL add_ovf_flags got %b exp 010", {carry, overflow, zero}); end
   endtask

   task automatic test_logic;
      logic [31:0] exp_r [4];
      exp_r[0] = 32'h00F0_1200; exp_r[1] = 32'hFFF0_FF34;
      exp_r[2] = 32'hFF00_ED34; exp_r[3] = 32'h000F_00CB;
      for (int i = 0; i < 4; i++) begin
         drive(4'(i), 32'hF0F0_1234, 32'h0FF0_FF00);
         n_vec++; if (res !== exp_r[i]) begin n_err++; $display("FAIL logic_op%0d got %h exp %h", i, res, exp_r[i]); end
         n_vec++; if ({done, carry, overflow} !== 3'b100) begin n_err++; $display("FAIL logic_flags_op%0d got %b exp 100", i, {done, carry, overflow}); end
      end
   endtask

   task automatic test_sub;
      drive(4'd6, 32'h8000_0000, 32'h1);
      n_vec++; if (res !== 32'h7FFF_FFFF) begin n_err++; $display("FAIL sub_ovf_res got %h exp 7fffffff", res); end
      n_vec++; if ({carry, overflow, zero} !== 3'b110) begin n_err++; $display("FAIL sub_ovf_flags got %b exp 110", {carry, overflow, zero}); end
      drive(4'd6, 32'd3, 32'd5);
      n_vec++; if (res !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL sub_borrow_res got %h exp fffffffe", res); end
      n_vec++; if ({carry, overflow, zero} !== 3'b000) begin n_err++; $display("FAIL sub_borrow_flags got %b exp 000", {carry, overflow, zero}); end
   endtask

   task automatic test_slt;
      drive(4'd4, 32'hFFFF_FFFF, 32'h1);
      n_vec++; if (res !== 32'h1) begin n_err++; $display("FAIL slt_neg got %h exp 1", res); end
      drive(4'd10, 32'hFFFF_FFFF, 32'h1);
      n_vec++; if ({res, zero} !== {32'h0, 1'b1}) begin n_err++; $display("FAIL sltu_big got %h/%b exp 0/1", res, zero); end
      drive(4'd4, 32'h1, 32'hFFFF_FFFF);
      n_vec++; if (res !== 32'h0) begin n_err++; $display("FAIL slt_pos got %h exp 0", res); end
      drive(4'd10, 32'h1, 32'hFFFF_FFFF);
      n_vec++; if (res !== 32'h1) begin n_err++; $display("FAIL sltu_small got %h exp 1", res); end
   endtask

   task automatic test_moddiv;
      int lat, nb;
      drive(4'd7, 32'd100, 32'd7);
      wait_done(1, lat, nb);
      n_vec++; if (lat !== 33) begin n_err++; $display("FAIL mod_latency got %0d exp 33", lat); end
      n_vec++; if (nb !== 32) begin n_err++; $display("FAIL mod_busy_cycles got %0d exp 32", nb); end
      n_vec++; if ({res, zero, busy} !== {32'd2, 2'b00}) begin n_err++; $display("FAIL mod_res got %h/%b%b exp 2/00", res, zero, busy); end
      drive(4'd8, 32'd100, 32'd7);
      wait_done(1, lat, nb);
      n_vec++; if ({lat, res} !== {32'd33, 32'd14}) begin n_err++; $display("FAIL div_res got lat %0d res %h exp 33/e", lat, res); end
      @(posedge clk); #1;
      n_vec++; if ({done, res} !== {1'b0, 32'd14}) begin n_err++; $display("FAIL div_hold got %b/%h exp 0/e", done, res); end
   endtask

   task automatic test_div_zero;
      drive(4'd8, 32'd5, 32'd0);
      n_vec++; if ({done, res} !== {1'b1, 32'hFFFF_FFFF}) begin n_err++; $display("FAIL divz_res got %b/%h exp 1/ffffffff", done, res); end
      n_vec++; if ({div_zero, carry, illegal} !== 3'b100) begin n_err++; $display("FAIL divz_flags got %b exp 100", {div_zero, carry, illegal}); end
      drive(4'd7, 32'd5, 32'd0);
      n_vec++; if ({done, res, div_zero} !== {1'b1, 32'd5, 1'b1}) begin n_err++; $display("FAIL modz_res got %b/%h/%b exp 1/5/1", done, res, div_zero); end
      @(posedge clk); #1;
      n_vec++; if ({done, div_zero} !== 2'b01) begin n_err++; $display("FAIL modz_flag_hold got %b exp 01", {done, div_zero}); end
   endtask

   task automatic test_mul_ignore;
      int lat, nb;
      drive(4'd9, 32'd3, 32'd7);
      n_vec++; if ({busy, done} !== 2'b10) begin n_err++; $display("FAIL mul_busy got %b exp 10", {busy, done}); end
      @(negedge clk);
      start = 1'b1; aluop = 4'd5; a = 32'd0; b = 32'd0;
      @(posedge clk); #1;
      start = 1'b0; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
      wait_done(2, lat, nb);
      n_vec++; if ({lat, nb} !== {32'd33, 32'd31}) begin n_err++; $display("FAIL mul_latency got %0d/%0d exp 33/31", lat, nb); end
      n_vec++; if (res !== 32'd21) begin n_err++; $display("FAIL mul_res got %h exp 15", res); end
      drive(4'd9, 32'h0001_0001, 32'h0001_0001);
      wait_done(1, lat, nb);
      n_vec++; if ({lat, res} !== {32'd33, 32'h0002_0001}) begin n_err++; $display("FAIL mul_trunc got %0d/%h exp 33/00020001", lat, res); end
   endtask

   task automatic test_back_to_back;
      drive(4'd5, 32'd10, 32'd20);
      n_vec++; if ({done, res} !== {1'b1, 32'd30}) begin n_err++; $display("FAIL b2b_first got %b/%h exp 1/1e", done, res); end
      drive(4'd6, 32'd5, 32'd5);
      n_vec++; if ({done, res} !== {1'b1, 32'd0}) begin n_err++; $display("FAIL b2b_second got %b/%h exp 1/0", done, res); end
      n_vec++; if ({carry, overflow, zero} !== 3'b101) begin n_err++; $display("FAIL b2b_flags got %b exp 101", {carry, overflow, zero}); end
   endtask

   task automatic test_reset_abort;
      int lat, nb;
      drive(4'd7, 32'd100, 32'd7);
      repeat (9) @(posedge clk);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      n_vec++; if ({busy, done, res} !== {2'b00, 32'd0}) begin n_err++; $display("FAIL abort_state got %b%b/%h exp 00/0", busy, done, res); end
      @(negedge clk); reset = 1'b1;
      @(posedge clk); #1;
      wait_done(1, lat, nb);
      n_vec++; if ({lat, nb} !== {32'd0, 32'd0}) begin n_err++; $display("FAIL abort_no_done got %0d/%0d exp 0/0", lat, nb); end
      drive(4'd12, 32'd9, 32'd9);
      n_vec++; if ({done, res, illegal, zero} !== {1'b1, 32'd0, 2'b11}) begin
         n_err++; $display("FAIL illegal_op got %b/%h/%b%b exp 1/0/11", done, res, illegal, zero); end
   endtask

   initial begin
      test_reset();
      test_add();
      test_logic();
      test_sub();
      test_slt();
      test_moddiv();
      test_div_zero();
      test_mul_ignore();
      test_back_to_back();
      test_reset_abort();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
